// File: rtl/output_writeback.sv
// Output writeback: shifts and narrows each result lane to 8 bits and writes one
// packed beat per cycle into the output BRAM, walking rows within tiles.
// Optional feature macro: WRITEBACK_SAT_EN (clamp lanes to [-128, 127] instead of wrapping).
module output_writeback #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      cfg_base_addr,
    input  logic [7:0]             cfg_rows,
    input  logic [7:0]             cfg_tiles,
    input  logic [ADDR_W-1:0]      cfg_tile_stride,
    input  logic [4:0]             cfg_shift,
    input  logic                   in_valid,
    input  logic [LANES*ACC_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   bram_en,
    output logic                   bram_we,
    output logic [ADDR_W-1:0]      bram_addr,
    output logic [LANES*8-1:0]     bram_din,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e              state_q, state_d;
    logic [7:0]          rows_q, tiles_q;
    logic [ADDR_W-1:0]   stride_q;
    logic [4:0]          shift_q;
    logic [ADDR_W-1:0]   tile_base_q;  // base + tile_cnt * stride, kept incrementally
    logic [7:0]          row_cnt_q, tile_cnt_q;
    logic                wr_pend_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LANES*8-1:0]  din_q;
    logic                done_q;

    logic                accept, last_row, last_tile, start_ok, start_nop;
    logic [LANES*8-1:0]  packed_din;

    // Next-state logic and handshake decode
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == StRun);
        accept    = in_valid && in_ready;
        last_row  = (row_cnt_q == (rows_q - 8'd1));
        last_tile = (tile_cnt_q == (tiles_q - 8'd1));
        start_ok  = (state_q == StIdle) && start && (cfg_rows != 8'd0) && (cfg_tiles != 8'd0);
        start_nop = (state_q == StIdle) && start && ((cfg_rows == 8'd0) || (cfg_tiles == 8'd0));
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (accept && last_row && last_tile) state_d = StFlush;
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Per-lane arithmetic shift, then wrap or clamp to a signed byte
    always_comb begin
        packed_din = '0;
        for (int i = 0; i < LANES; i++) begin : g_lane
`ifdef WRITEBACK_SAT_EN
            logic signed [ACC_W-1:0] sh;
            sh = $signed(in_data[ACC_W*i +: ACC_W]) >>> shift_q;
            if (sh > 127)       packed_din[8*i +: 8] = 8'h7F;
            else if (sh < -128) packed_din[8*i +: 8] = 8'h80;
            else                packed_din[8*i +: 8] = 8'(sh);
`else
            packed_din[8*i +: 8] = 8'($signed(in_data[ACC_W*i +: ACC_W]) >>> shift_q);
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Configuration latch, row/tile walk, write pipeline stage and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q      <= '0;
            tiles_q     <= '0;
            stride_q    <= '0;
            shift_q     <= '0;
            tile_base_q <= '0;
            row_cnt_q   <= '0;
            tile_cnt_q  <= '0;
            wr_pend_q   <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            wr_pend_q <= accept;
            done_q    <= start_nop || (state_q == StFlush);
            if (start_ok) begin
                rows_q      <= cfg_rows;
                tiles_q     <= cfg_tiles;
                stride_q    <= cfg_tile_stride;
                shift_q     <= cfg_shift;
                tile_base_q <= cfg_base_addr;
                row_cnt_q   <= '0;
                tile_cnt_q  <= '0;
            end else if (accept) begin
                addr_q <= tile_base_q + ADDR_W'(row_cnt_q);
                din_q  <= packed_din;
                if (last_row) begin
                    row_cnt_q   <= '0;
                    tile_cnt_q  <= tile_cnt_q + 8'd1;
                    tile_base_q <= tile_base_q + stride_q;
                end else begin
                    row_cnt_q <= row_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bram_en   = wr_pend_q;
    assign bram_we   = wr_pend_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign busy      = (state_q == StRun) || wr_pend_q;
    assign done      = done_q;

endmodule

// File: tb/tb_output_writeback.sv
// Scoreboard bench for output_writeback: a driver pushes expected writes and done
// pulses (with the cycle they must appear in) and a negedge monitor pops and compares.
module tb_output_writeback;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [11:0]  cfg_base_addr = '0;
    logic [7:0]   cfg_rows = '0;
    logic [7:0]   cfg_tiles = '0;
    logic [11:0]  cfg_tile_stride = '0;
    logic [4:0]   cfg_shift = '0;
    logic         in_valid = 1'b0;
    logic [255:0] in_data = '0;
    logic         in_ready, bram_en, bram_we, busy, done;
    logic [11:0]  bram_addr;
    logic [63:0]  bram_din;

    output_writeback dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr),
        .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles), .cfg_tile_stride(cfg_tile_stride),
        .cfg_shift(cfg_shift), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic [63:0] din;
        int          cyc;
    } wr_t;

    wr_t    exp_q[$];
    int     done_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    bit     mon_on = 1'b0;
    bit     use_fixed = 1'b0;
    logic [255:0] fixed_beat;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: each lane as a signed integer, shifted, then wrapped or clamped to a byte
    function automatic logic [63:0] model_din(input logic [255:0] d, input int sh);
        logic [63:0] r;
        int          v;
        for (int i = 0; i < 8; i++) begin
            v = int'($signed(d[32*i +: 32]));
            v = v >>> sh;
`ifdef WRITEBACK_SAT_EN
            if (v > 127) v = 127;
            if (v < -128) v = -128;
`endif
            r[8*i +: 8] = v[7:0];
        end
        return r;
    endfunction

    // Monitor: every write and done pulse must match the head of its queue
    always @(negedge clk) begin
        if (mon_on) begin
            if (bram_en !== bram_we) check("en_eq_we", {63'd0, bram_en}, {63'd0, bram_we});
            if (bram_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", {52'd0, bram_addr}, {52'd0, e.addr});
                    check("wr_din", bram_din, e.din);
                    check("wr_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (done === 1'b1) begin
                if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0 && done_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size() + done_q.size()), 64'd0);
            exp_q.delete();
            done_q.delete();
        end
    endtask

    // vmode: 0 valid held high, 1 toggling 1,0,1,0, 2 random
    task automatic run_job(input logic [11:0] base, input logic [11:0] stride, input int rows,
                           input int tiles, input int sh, input int vmode, input int restart_at,
                           input int rst_after);
        int  total, k, n;
        bit  v, restarted;
        logic [255:0] d;
        total = rows * tiles;
        @(negedge clk);
        cfg_base_addr = base; cfg_tile_stride = stride;
        cfg_rows = 8'(rows); cfg_tiles = 8'(tiles); cfg_shift = 5'(sh);
        start = 1'b1;
        if (total == 0) begin
            done_q.push_back(cyc + 1);
            @(negedge clk);
            start = 1'b0;
            #1;
            check("nop_busy", {63'd0, busy}, 64'd0);
            check("nop_ready", {63'd0, in_ready}, 64'd0);
            drain();
            return;
        end
        k = 0; n = 0; restarted = 1'b0;
        while (k < total) begin
            @(negedge clk);
            // scramble cfg inputs: the latched copy must be used
            cfg_base_addr = 12'($urandom); cfg_tile_stride = 12'($urandom);
            cfg_rows = 8'($urandom_range(1, 9)); cfg_tiles = 8'($urandom_range(1, 9));
            cfg_shift = 5'($urandom);
            start = 1'b0;
            if (restart_at >= 0 && k == restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((n % 2) == 0) : ($urandom_range(0, 3) != 0);
            d = use_fixed ? fixed_beat : {8{$urandom}};
            in_valid = v;
            in_data  = d;
            n++;
            #1;
            check("run_ready", {63'd0, in_ready}, 64'd1);
            check("run_busy", {63'd0, busy}, 64'd1);
            if (v) begin
                wr_t e;
                int  a;
                a = int'(base) + (k / rows) * int'(stride) + (k % rows);
                e.addr = 12'(a);
                e.din  = model_din(d, sh);
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
                k++;
                if (k == total) done_q.push_back(cyc + 2);
                if (rst_after > 0 && k == rst_after) break;
            end
        end
        if (rst_after > 0) begin
            @(negedge clk);
            in_valid = 1'b0; start = 1'b0; rst = 1'b1;
            @(negedge clk);
            #1;
            check("rst_ready", {63'd0, in_ready}, 64'd0);
            check("rst_en", {63'd0, bram_en}, 64'd0);
            check("rst_we", {63'd0, bram_we}, 64'd0);
            check("rst_addr", {52'd0, bram_addr}, 64'd0);
            check("rst_din", bram_din, 64'd0);
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_done", {63'd0, done}, 64'd0);
            rst = 1'b0;
            drain();
            repeat (10) @(negedge clk);
            return;
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        #1;
        check("flush_ready", {63'd0, in_ready}, 64'd0);
        check("flush_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        #1;
        check("done_busy", {63'd0, busy}, 64'd0);
        drain();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", {63'd0, in_ready}, 64'd0);
        check("reset_en", {63'd0, bram_en}, 64'd0);
        check("reset_we", {63'd0, bram_we}, 64'd0);
        check("reset_addr", {52'd0, bram_addr}, 64'd0);
        check("reset_din", bram_din, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        mon_on = 1'b1;

        // Two tiles of four rows, back-to-back
        run_job(12'h010, 12'h020, 4, 2, 0, 0, -1, 0);
        // Address wrap past the top of the BRAM
        run_job(12'hFFE, 12'h000, 4, 1, 0, 0, -1, 0);
        // Narrowing corner cases: positive overflow after shift, negative overflow
        use_fixed = 1'b1;
        fixed_beat = {32'h7FFF_FFFF, 32'h8000_0000, 32'd127, -32'sd128, 32'd128, -32'sd129,
                      -32'sd1000, 32'h0000_0300};
        run_job(12'h100, 12'h000, 1, 1, 2, 0, -1, 0);
        run_job(12'h101, 12'h000, 1, 1, 0, 0, -1, 0);
        use_fixed = 1'b0;
        // Gapped input: 1,0,1,0
        run_job(12'h200, 12'h040, 2, 1, 0, 1, -1, 0);
        // Degenerate jobs
        run_job(12'h300, 12'h010, 3, 0, 0, 0, -1, 0);
        run_job(12'h300, 12'h010, 0, 2, 0, 0, -1, 0);
        // Second start mid-job is ignored
        run_job(12'h400, 12'h008, 3, 2, 1, 0, 2, 0);
        // Random jobs
        for (int j = 0; j < 12; j++)
            run_job(12'($urandom), 12'($urandom), $urandom_range(1, 6), $urandom_range(1, 3),
                    $urandom_range(0, 12), 2, ($urandom_range(0, 1) == 1) ? 1 : -1, 0);
        // Reset after three of eight beats
        run_job(12'h500, 12'h020, 4, 2, 0, 0, -1, 3);
        // Block still usable after the abandoned job
        run_job(12'h600, 12'h010, 2, 2, 3, 2, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
